// File: rtl/follower_pkg.sv
// Shared types and constants for the line-follower station-ID path.
package follower_pkg;

  localparam int ID_W = 8;
  localparam int BC_PRD_W = 22;
  localparam logic [ID_W-1:0] ID_RSVD_MASK = 8'hC0;

  typedef enum logic [2:0] {
    IDLE,
    START,
    WAIT_FALL,
    SAMPLE,
    DONE
  } bc_state_t;

  // Station IDs with either reserved top bit set are not valid stations.
  function automatic logic id_ok(input logic [ID_W-1:0] id);
    return (id & ID_RSVD_MASK) == '0;
  endfunction

endpackage

// File: rtl/bc_sync.sv
// Barcode line synchronizer: two metastability flops plus one history flop
// for falling-edge detect. Flops preset to 1 so reset looks like an idle line.
module bc_sync (
  input  logic clk,
  input  logic rst,
  input  logic bc,
  output logic bc_s,
  output logic fall
);

  logic [2:0] sync;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) sync <= 3'b111;
    else     sync <= {sync[1:0], bc};
  end

  assign bc_s = sync[1];
  assign fall = sync[2] & ~sync[1];

endmodule

// File: rtl/barcode_rdr.sv
// Station-ID barcode reader: measures the start-bit low width and samples each
// data bit that many cycles after its falling edge. Macro BC_ID_CHECK_EN rejects reserved IDs.
module barcode_rdr
  import follower_pkg::*;
#(
  parameter int PRD_W = BC_PRD_W
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            BC,
  input  logic            clr_ID_vld,
  output logic [ID_W-1:0] ID,
  output logic            ID_vld,
  output logic            in_frame
);

  bc_state_t        state, state_nxt;
  logic [PRD_W-1:0] dur_cnt;
  logic [PRD_W-1:0] low_len;
  logic [2:0]       bit_cnt;
  logic [ID_W-1:0]  shft;
  logic             bc_s, fall;
  logic             dur_clr, dur_inc, len_ld, smp, done, accept;

  bc_sync u_sync (
    .clk  (clk),
    .rst  (rst),
    .bc   (BC),
    .bc_s (bc_s),
    .fall (fall)
  );

`ifdef BC_ID_CHECK_EN
  assign accept = id_ok(shft);
`else
  assign accept = 1'b1;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    dur_clr   = 1'b0;
    dur_inc   = 1'b0;
    len_ld    = 1'b0;
    smp       = 1'b0;
    done      = 1'b0;
    case (state)
      IDLE: begin
        if (fall) begin
          dur_clr   = 1'b1;
          state_nxt = START;
        end
      end
      START: begin
        if (!bc_s) begin
          dur_inc = 1'b1;
        end else begin
          len_ld    = 1'b1;
          state_nxt = WAIT_FALL;
        end
      end
      WAIT_FALL: begin
        if (fall) begin
          dur_clr   = 1'b1;
          state_nxt = SAMPLE;
        end
      end
      SAMPLE: begin
        dur_inc = 1'b1;
        if (dur_cnt == low_len) begin
          smp       = 1'b1;
          state_nxt = (bit_cnt == 3'd7) ? DONE : WAIT_FALL;
        end
      end
      DONE: begin
        done      = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Duration counter saturates so an over-long start bit cannot alias short.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      dur_cnt <= '0;
      low_len <= '0;
      bit_cnt <= '0;
      shft    <= '0;
    end else begin
      if (dur_clr)
        dur_cnt <= '0;
      else if (dur_inc && (dur_cnt != '1))
        dur_cnt <= dur_cnt + 1'b1;
      if (len_ld) begin
        low_len <= dur_cnt;
        bit_cnt <= '0;
      end
      if (smp) begin
        shft    <= {shft[ID_W-2:0], bc_s};
        bit_cnt <= bit_cnt + 1'b1;
      end
    end
  end

  // A load in DONE takes priority over a coincident clear.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ID       <= '0;
      ID_vld   <= 1'b0;
      in_frame <= 1'b0;
    end else begin
      in_frame <= (state_nxt != IDLE);
      if (done) begin
        if (accept) begin
          ID     <= shft;
          ID_vld <= 1'b1;
        end
      end else if (clr_ID_vld) begin
        ID_vld <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_barcode_rdr.sv
// Self-checking bench for barcode_rdr: frame driver with a scoreboard queue,
// plus a narrow-counter instance to exercise start-width saturation.
module tb_barcode_rdr;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       bc  = 1'b1;
  logic       clr = 1'b0;
  logic [7:0] id;
  logic       id_vld, in_frame;

  logic       bc2  = 1'b1;
  logic       clr2 = 1'b0;
  logic [7:0] id2;
  logic       vld2, inf2;

  barcode_rdr dut (
    .clk        (clk),
    .rst        (rst),
    .BC         (bc),
    .clr_ID_vld (clr),
    .ID         (id),
    .ID_vld     (id_vld),
    .in_frame   (in_frame)
  );

  barcode_rdr #(.PRD_W(6)) dut_s (
    .clk        (clk),
    .rst        (rst),
    .BC         (bc2),
    .clr_ID_vld (clr2),
    .ID         (id2),
    .ID_vld     (vld2),
    .in_frame   (inf2)
  );

  always #5 clk = ~clk;

`ifdef BC_ID_CHECK_EN
  localparam bit ID_CHECK = 1'b1;
`else
  localparam bit ID_CHECK = 1'b0;
`endif

  typedef struct {
    logic [7:0] id;
    logic       vld;
  } exp_t;

  exp_t       sb[$];
  logic [7:0] model_id = 8'h00;
  int         checks = 0;
  int         errors = 0;
  event       last_fall_ev;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  function automatic bit accepted(input logic [7:0] v);
    return !ID_CHECK || (v < 8'd64);
  endfunction

  // Start bit low T/2, data '1' low T/4, data '0' low 3T/4, MSB first.
  task automatic send_frame(input logic [7:0] v, input int t, input bit expect_it, input int nbits);
    int lo;
    exp_t e;
    if (expect_it) begin
      e.vld = accepted(v);
      e.id  = e.vld ? v : model_id;
      if (e.vld) model_id = v;
      sb.push_back(e);
    end
    bc = 1'b0;
    repeat (t / 2) @(negedge clk);
    bc = 1'b1;
    repeat (t - t / 2) @(negedge clk);
    for (int i = 7; i > 7 - nbits; i--) begin
      bc = 1'b0;
      if (i == 0) ->last_fall_ev;
      lo = v[i] ? t / 4 : (3 * t) / 4;
      repeat (lo) @(negedge clk);
      bc = 1'b1;
      repeat (t - lo) @(negedge clk);
    end
  endtask

  task automatic clr_pulse();
    clr = 1'b1;
    @(negedge clk);
    clr = 1'b0;
  endtask

  // Monitor: every end of a frame must match the next scoreboard entry.
  initial begin
    logic prev;
    exp_t e;
    prev = 1'b0;
    forever begin
      @(negedge clk);
      if (rst) begin
        prev = 1'b0;
      end else begin
        if (prev && !in_frame) begin
          if (sb.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_frame actual ID=%0h required no frame", id);
          end else begin
            e = sb.pop_front();
            check("frame_id", {24'h0, id}, {24'h0, e.id});
            check("frame_vld", {31'h0, id_vld}, {31'h0, e.vld});
          end
        end
        prev = in_frame;
      end
    end
  end

  initial begin
    logic [7:0] v;
    int t;
    logic [7:0] sat_id;
    int lo;

    rst = 1'b1;
    repeat (3) @(negedge clk);
    check("rst_id", {24'h0, id}, 32'h0);
    check("rst_vld", {31'h0, id_vld}, 32'h0);
    check("rst_in_frame", {31'h0, in_frame}, 32'h0);
    rst = 1'b0;
    repeat (5) @(negedge clk);

    // Over-long start bit on the 6-bit instance: length must stick at 63.
    sat_id = 8'h25;
    bc2 = 1'b0;
    repeat (200) @(negedge clk);
    check("sat_in_frame", {31'h0, inf2}, 32'h1);
    check("sat_no_vld", {31'h0, vld2}, 32'h0);
    bc2 = 1'b1;
    repeat (30) @(negedge clk);
    for (int i = 7; i >= 0; i--) begin
      bc2 = 1'b0;
      lo = sat_id[i] ? 20 : 100;
      repeat (lo) @(negedge clk);
      bc2 = 1'b1;
      repeat (130 - lo) @(negedge clk);
    end
    check("sat_id", {24'h0, id2}, {24'h0, sat_id});
    check("sat_vld", {31'h0, vld2}, 32'h1);

    send_frame(8'h2A, 522, 1'b1, 8);
    clr_pulse();
    repeat (5) @(negedge clk);
    send_frame(8'hC5, 522, 1'b1, 8);
    clr_pulse();

    // Clear coincident with DONE, then again one cycle later.
    fork
      send_frame(8'h12, 522, 1'b1, 8);
      begin
        @(last_fall_ev);
        repeat (261 + 3) @(negedge clk);
        clr = 1'b1;
        @(negedge clk);
        check("set_wins", {31'h0, id_vld}, 32'h1);
        @(negedge clk);
        clr = 1'b0;
        check("clr_after", {31'h0, id_vld}, 32'h0);
      end
    join
    clr_pulse();

    // Reset after four data bits with the line idle high.
    send_frame(8'hAA, 522, 1'b0, 4);
    rst = 1'b1;
    @(negedge clk);
    check("midrst_in_frame", {31'h0, in_frame}, 32'h0);
    check("midrst_id", {24'h0, id}, 32'h0);
    check("midrst_vld", {31'h0, id_vld}, 32'h0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    model_id = 8'h00;
    repeat (10) @(negedge clk);
    send_frame(8'h15, 522, 1'b1, 8);
    clr_pulse();

    send_frame(8'h01, 200, 1'b1, 8);
    clr_pulse();
    send_frame(8'h3F, 200, 1'b1, 8);
    clr_pulse();
    send_frame(8'h3C, 4000, 1'b1, 8);
    clr_pulse();

    for (int n = 0; n < 4; n++) begin
      v = 8'($urandom_range(0, 255));
      t = int'($urandom_range(120, 300));
      send_frame(v, t, 1'b1, 8);
      clr_pulse();
    end

    repeat (20) @(negedge clk);
    check("sb_drained", sb.size(), 32'h0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
